psum_accum: RTL and testbench
=============================

PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 SHALL have parameter col, default 8: number of array columns / output lanes.
REQ-002 SHALL have parameter psum_bw, default 16: signed partial-sum width per lane.
REQ-003 SHALL have parameter depth, default 16: accumulator rows; max rows per tile.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that launches a tile; sampled only in IDLE.
REQ-007 SHALL have port num_rows, input, $clog2(depth)+1: rows per pass, sampled on start.
REQ-008 SHALL have port num_pass, input, 4: accumulation passes per tile, sampled on start.
REQ-009 SHALL have port ofifo_valid, input, 1: upstream output FIFO holds at least one row.
REQ-010 SHALL have port ofifo_rd, output, 1: read strobe to the upstream output FIFO.
REQ-011 SHALL have port ofifo_out, input, col*psum_bw: FIFO row, valid the cycle after ofifo_rd; lane k at bits [k*psum_bw +: psum_bw].
REQ-012 SHALL have port out_data, output, col*psum_bw: finished row, same lane packing.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream valid/ready handshake.
REQ-014 SHALL have ports busy (output, 1; high outside IDLE) and done (output, 1; one-cycle pulse at tile end).

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DRAIN, FIN.
REQ-016 IDLE->ACC on start; num_pass==0 SHALL be treated as 1; num_rows==0 SHALL go IDLE->FIN with no FIFO reads.
REQ-017 In ACC, ofifo_rd SHALL assert for one cycle only when ofifo_valid=1 and no read is outstanding; at most one read in flight.
REQ-018 The cycle after ofifo_rd, ofifo_out SHALL be captured into accumulator row r (r = row counter, 0..num_rows-1).
REQ-019 Pass 0 SHALL overwrite row r; passes >=1 SHALL add per lane in signed two's complement, wrapping modulo 2^psum_bw (no saturation).
REQ-020 Row counter SHALL wrap to 0 after num_rows-1 and increment the pass counter; after last row of last pass, ACC->DRAIN.
REQ-021 In DRAIN, out_valid SHALL be high with rows presented in order 0..num_rows-1; a row advances only on out_valid&&out_ready.
REQ-022 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 After the last row handshake, DRAIN->FIN; FIN SHALL pulse done for one cycle then return to IDLE.
REQ-024 start asserted outside IDLE SHALL be ignored.
REQ-025 ofifo_valid low in ACC SHALL stall without state loss; ofifo_rd SHALL never assert outside ACC.

Reset
REQ-026 reset_n low SHALL immediately force IDLE; ofifo_rd, out_valid, busy, done = 0; out_data = 0; counters and in-flight flag cleared.
REQ-027 Accumulator contents SHALL be cleared on reset; reset mid-tile SHALL abandon the tile, with no done pulse.

Configuration
REQ-028 With macro PSUM_RELU_EN defined, each out_data lane SHALL be max(lane,0) (negative -> 0); accumulator contents unaffected.
REQ-029 Without PSUM_RELU_EN, out_data lanes SHALL pass the accumulated value unchanged.

Structure
REQ-030 Package psum_pkg SHALL hold the FSM state enum and default col/psum_bw/depth constants.
REQ-031 Sub-module psum_lane SHALL implement one lane: overwrite/add select, wrapping adder, optional ReLU; instantiated col times.

Verification
REQ-032 num_rows=4, num_pass=1, FIFO rows lane0=1,2,3,4 -> out rows lane0=1,2,3,4, then done one cycle after the 4th handshake.
REQ-033 num_rows=2, num_pass=3, every FIFO row lane0=0x0005 -> out lane0=0x000F both rows; exactly 6 ofifo_rd pulses.
REQ-034 Lane0 accumulates 0x7FFF+0x0001 -> 0x8000 without PSUM_RELU_EN; 0x0000 with it defined.
REQ-035 out_ready held 0 for 5 cycles during DRAIN -> out_data/out_valid constant, no row skipped or duplicated.
REQ-036 ofifo_valid toggled 1-0-1 every cycle in ACC -> no ofifo_rd while ofifo_valid=0; results match the unstalled run.
REQ-037 reset_n low during ACC row 2 -> next cycle busy=0, ofifo_rd=0, no done; a new start then yields correct results.

Source files
------------

// File: rtl/psum_pkg.sv
// psum_accum shared types and default sizing.
// FSM state encoding plus column/width/depth defaults.
package psum_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/psum_lane.sv
// One accumulator lane: overwrite/add select with wrapping add,
// plus the output clamp (ReLU when PSUM_RELU_EN is defined).
module psum_lane
  import psum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEF
) (
  input  logic               i_add,
  input  logic [psum_bw-1:0] i_acc,
  input  logic [psum_bw-1:0] i_in,
  output logic [psum_bw-1:0] o_sum,
  input  logic [psum_bw-1:0] i_row,
  output logic [psum_bw-1:0] o_out
);

  // Two's complement add simply drops the carry, giving the wrap.
  assign o_sum = i_add ? (i_acc + i_in) : i_in;

`ifdef PSUM_RELU_EN
  assign o_out = i_row[psum_bw-1] ? '0 : i_row;
`else
  assign o_out = i_row;
`endif

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: gathers num_pass passes of num_rows rows
// from the output FIFO, then drains them. Optional: PSUM_RELU_EN.
module psum_accum
  import psum_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int depth   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [$clog2(depth):0]     num_rows,
  input  logic [3:0]                 num_pass,
  input  logic                       ofifo_valid,
  output logic                       ofifo_rd,
  input  logic [col*psum_bw-1:0]     ofifo_out,
  output logic [col*psum_bw-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = $clog2(depth) + 1;
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int DW = col * psum_bw;
  localparam logic [RW-1:0] R_ONE = RW'(1);
  localparam logic [RW-1:0] R_MAX = RW'(depth);

  state_t r_state;
  state_t w_next;

  logic [RW-1:0] r_rows;
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_orow;
  logic [3:0]    r_npass;
  logic [3:0]    r_pass;
  logic          r_infl;
  logic [DW-1:0] r_acc [depth];

  logic          w_rd;
  logic          w_cap;
  logic          w_hs;
  logic          w_last_row;
  logic          w_last_pass;
  logic          w_last_out;
  logic [RW-1:0] w_nrows;
  logic [DW-1:0] w_cur;
  logic [DW-1:0] w_drow;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_out;

  // Rows beyond the storage depth are clamped to it.
  assign w_nrows = (num_rows > R_MAX) ? R_MAX : num_rows;

  assign w_cap       = (r_state == ACC) && r_infl;
  assign w_hs        = out_valid && out_ready;
  assign w_last_row  = (r_row == r_rows - R_ONE);
  assign w_last_pass = (r_pass == r_npass - 4'd1);
  assign w_last_out  = (r_orow == r_rows - R_ONE);

  assign w_cur  = r_acc[r_row[AW-1:0]];
  assign w_drow = r_acc[r_orow[AW-1:0]];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and FIFO read strobe.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (num_rows == '0) ? FIN : ACC;
        end
      end
      ACC: begin
        w_rd = ofifo_valid && !r_infl;
        if (w_cap && w_last_row && w_last_pass) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_hs && w_last_out) begin
          w_next = FIN;
        end
      end
      FIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign ofifo_rd  = w_rd;
  assign out_valid = (r_state == DRAIN);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign out_data  = out_valid ? w_out : '0;

  // Tile configuration latched on an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rows  <= '0;
      r_npass <= '0;
    end else if (r_state == IDLE && start) begin
      r_rows  <= w_nrows;
      r_npass <= (num_pass == 4'd0) ? 4'd1 : num_pass;
    end
  end

  // Single outstanding read: set on the strobe, cleared on capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_infl <= 1'b0;
    end else if (r_state == ACC) begin
      r_infl <= w_rd;
    end else begin
      r_infl <= 1'b0;
    end
  end

  // Row and pass counters for the accumulate phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row  <= '0;
      r_pass <= '0;
    end else if (r_state == IDLE && start) begin
      r_row  <= '0;
      r_pass <= '0;
    end else if (w_cap) begin
      if (w_last_row) begin
        r_row  <= '0;
        r_pass <= r_pass + 4'd1;
      end else begin
        r_row  <= r_row + R_ONE;
      end
    end
  end

  // Drain row pointer advances on each output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_orow <= '0;
    end else if (r_state == IDLE && start) begin
      r_orow <= '0;
    end else if (w_hs) begin
      r_orow <= r_orow + R_ONE;
    end
  end

  // Accumulator rows: written one row per captured FIFO beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_cap) begin
      r_acc[r_row[AW-1:0]] <= w_sum;
    end
  end

  for (genvar k = 0; k < col; k++) begin : g_lane
    psum_lane #(
      .psum_bw (psum_bw)
    ) u_lane (
      .i_add (r_pass != 4'd0),
      .i_acc (w_cur[k*psum_bw +: psum_bw]),
      .i_in  (ofifo_out[k*psum_bw +: psum_bw]),
      .o_sum (w_sum[k*psum_bw +: psum_bw]),
      .i_row (w_drow[k*psum_bw +: psum_bw]),
      .o_out (w_out[k*psum_bw +: psum_bw])
    );
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: FIFO model on the input side,
// hand-computed row values checked on the drain side.
module tb_psum_accum;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int DW    = COL * BW;
  localparam int RW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic [3:0]    num_pass = '0;
  logic          ofifo_valid = 1'b0;
  logic          ofifo_rd;
  logic [DW-1:0] ofifo_out = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int rd_bad = 0;
  int base;
  bit tog = 1'b0;

  logic [DW-1:0] fmem [$];
  logic [BW-1:0] exp0 [DEPTH];
  logic [BW-1:0] exp1 [DEPTH];

  always #5 clk = ~clk;

  psum_accum #(
    .col     (COL),
    .psum_bw (BW),
    .depth   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .num_rows    (num_rows),
    .num_pass    (num_pass),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd    (ofifo_rd),
    .ofifo_out   (ofifo_out),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  // Upstream FIFO model: data lands the cycle after the read strobe.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (ofifo_rd) begin
      rd_cnt++;
      if (!ofifo_valid) rd_bad++;
      if (fmem.size() > 0) begin
        w = fmem.pop_front();
        ofifo_out <= w;
      end
    end
    ofifo_valid <= (fmem.size() > 0) && (!tog || !ofifo_valid);
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef PSUM_RELU_EN
    return v[BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] mkrow(input logic [BW-1:0] l0,
                                          input logic [BW-1:0] l1);
    logic [DW-1:0] r;
    r = '0;
    r[BW-1:0]    = l0;
    r[2*BW-1:BW] = l1;
    return r;
  endfunction

  task automatic launch(input int nr, input int np);
    @(negedge clk);
    num_rows = RW'(nr);
    num_pass = 4'(np);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int n, input int stall_row);
    int idx;
    bit stalled;
    logic [DW-1:0] snap;
    idx = 0;
    stalled = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && idx < n; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (idx == stall_row && !stalled) begin
          stalled = 1'b1;
          out_ready = 1'b0;
          snap = out_data;
          repeat (5) begin
            @(negedge clk);
            chk("stall_valid", DW'(out_valid), DW'(1));
            chk("stall_data", out_data, snap);
          end
          out_ready = 1'b1;
        end
        chk($sformatf("row%0d_l0", idx), DW'(out_data[BW-1:0]),
            DW'(relu(exp0[idx])));
        chk($sformatf("row%0d_l1", idx), DW'(out_data[2*BW-1:BW]),
            DW'(relu(exp1[idx])));
        idx++;
      end
    end
    if (idx < n) begin
      chk("drain_timeout", DW'(idx), DW'(n));
    end else begin
      @(negedge clk);
      chk("done_pulse", DW'(done), DW'(1));
      chk("fin_valid", DW'(out_valid), DW'(0));
      @(negedge clk);
      chk("done_clear", DW'(done), DW'(0));
      chk("idle_busy", DW'(busy), DW'(0));
    end
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_rd", DW'(ofifo_rd), DW'(0));
    chk("rst_data", out_data, DW'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Single pass, four rows, with a 5-cycle output stall on row 1.
    for (int k = 0; k < 4; k++) begin
      fmem.push_back(mkrow(BW'(k + 1), BW'(-(k + 1))));
      exp0[k] = BW'(k + 1);
      exp1[k] = BW'(-(k + 1));
    end
    base = rd_cnt;
    launch(4, 1);
    chk("t1_busy", DW'(busy), DW'(1));
    drain(4, 1);
    chk("t1_reads", DW'(rd_cnt - base), DW'(4));

    // Three passes over two rows; a stray start mid-tile is ignored.
    for (int k = 0; k < 6; k++) begin
      fmem.push_back(mkrow(16'h0005, 16'h0100));
    end
    exp0[0] = 16'h000F; exp0[1] = 16'h000F;
    exp1[0] = 16'h0300; exp1[1] = 16'h0300;
    base = rd_cnt;
    launch(2, 3);
    @(negedge clk);
    @(negedge clk);
    num_rows = RW'(1);
    num_pass = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(2, -1);
    chk("t2_reads", DW'(rd_cnt - base), DW'(6));

    // Wrap-around of a signed lane.
    fmem.push_back(mkrow(16'h7FFF, 16'hFFFF));
    fmem.push_back(mkrow(16'h0001, 16'hFFFF));
    exp0[0] = 16'h8000;
    exp1[0] = 16'hFFFE;
    base = rd_cnt;
    launch(1, 2);
    drain(1, -1);
    chk("t3_reads", DW'(rd_cnt - base), DW'(2));

    // num_pass of zero behaves as a single pass.
    fmem.push_back(mkrow(16'h1234, 16'h0042));
    exp0[0] = 16'h1234;
    exp1[0] = 16'h0042;
    base = rd_cnt;
    launch(1, 0);
    drain(1, -1);
    chk("t4_reads", DW'(rd_cnt - base), DW'(1));

    // Toggling FIFO valid gives the same results as the unstalled run.
    tog = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fmem.push_back(mkrow(BW'(k + 1), BW'(-(k + 1))));
      exp0[k] = BW'(k + 1);
      exp1[k] = BW'(-(k + 1));
    end
    base = rd_cnt;
    launch(4, 1);
    drain(4, -1);
    chk("t5_reads", DW'(rd_cnt - base), DW'(4));
    chk("t5_rd_no_valid", DW'(rd_bad), DW'(0));
    tog = 1'b0;

    // Zero rows: straight to done, no reads.
    base = rd_cnt;
    launch(0, 1);
    chk("t6_done", DW'(done), DW'(1));
    @(negedge clk);
    chk("t6_done_clear", DW'(done), DW'(0));
    chk("t6_busy", DW'(busy), DW'(0));
    chk("t6_reads", DW'(rd_cnt - base), DW'(0));

    // Reset while accumulating row 2, then a clean tile.
    for (int k = 0; k < 4; k++) begin
      fmem.push_back(mkrow(BW'(10 * (k + 1)), 16'h0000));
    end
    base = rd_cnt;
    launch(4, 1);
    for (int cyc = 0; cyc < 100 && (rd_cnt - base) < 3; cyc++) begin
      @(negedge clk);
    end
    chk("t7_reached_row2", DW'(rd_cnt - base), DW'(3));
    reset_n = 1'b0;
    #1;
    chk("t7_busy", DW'(busy), DW'(0));
    chk("t7_rd", DW'(ofifo_rd), DW'(0));
    chk("t7_valid", DW'(out_valid), DW'(0));
    chk("t7_data", out_data, DW'(0));
    @(negedge clk);
    chk("t7_no_done", DW'(done), DW'(0));
    chk("t7_busy2", DW'(busy), DW'(0));
    fmem.delete();
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      fmem.push_back(mkrow(BW'(7 + k), BW'(16'h8000 + k)));
      exp0[k] = BW'(7 + k);
      exp1[k] = BW'(16'h8000 + k);
    end
    base = rd_cnt;
    launch(3, 1);
    drain(3, 2);
    chk("t7_reads", DW'(rd_cnt - base), DW'(3));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
